display_capture: RTL
====================

DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 4096: number of cycles with no accepted digit advance before the scan is declared stalled (legal range 2..65535).
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port nReset  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port D  input  4  BCD data for the currently selected digit.
REQ-005 SHALL have port Digit  input  4  one-hot digit select: Digit[3] is the leftmost digit (slot 3), Digit[0] is the rightmost digit (slot 0), and 0000 means blank.
REQ-006 SHALL have port DP  input  1  decimal point for the currently selected digit.
REQ-007 SHALL have port Value  output  16  committed frame, holding slot n in bits [4n+3:4n].
REQ-008 SHALL have port DPMask  output  4  committed decimal points, with bit n belonging to slot n.
REQ-009 SHALL have port FrameStrobe  output  1  one-cycle pulse on each commit.
REQ-010 SHALL have port FrameValid  output  1  indicates that Value/DPMask hold a frame committed since the last stall or reset.
REQ-011 SHALL have port SeqErr  output  1  one-cycle pulse on an out-of-order select or a multi-hot select.
REQ-012 SHALL have port BcdErr  output  1  one-cycle pulse when D>9 is captured.
REQ-013 SHALL have port Stalled  output  1  level, set on scan timeout.

Function
REQ-014 SHALL sample D, Digit and DP on every rising Clock edge; no input synchronisers (inputs are synchronous to Clock).
REQ-015 SHALL implement FSM states HUNT, S3, S2, S1, S0, where Sn means slot n is currently being captured.
REQ-016 SHALL, in HUNT, ignore all selects except 1000; on 1000 go to S3, clear the shadow bad flag and the shadow.
REQ-017 SHALL, in state Sn while Digit selects slot n, write D and DP into shadow slot n on every such cycle (last sample wins).
REQ-018 SHALL treat Digit=0000 in any Sn as blanking: hold state, capture nothing, and count toward timeout.
REQ-019 SHALL advance S3->S2->S1->S0 when Digit becomes the next lower one-hot value.
REQ-020 SHALL, in S0 when Digit becomes 1000, commit shadow to Value/DPMask, pulse FrameStrobe, set FrameValid, clear Stalled, and go to S3 with the shadow cleared. If the shadow bad flag is set, no commit and no strobe occur; the state still goes to S3.
REQ-021 SHALL make the Value/DPMask update and FrameStrobe=1 visible in the cycle after the edge that sampled the 1000 select (one-cycle latency).
REQ-022 SHALL, on any other one-hot select in Sn, pulse SeqErr. If that select is 1000, go to S3 with the shadow cleared; otherwise go to HUNT. Value is not changed.
REQ-023 SHALL, on a multi-hot Digit in any state, pulse SeqErr, go to HUNT, and leave Value unchanged.
REQ-024 SHALL, when a captured D>9, pulse BcdErr and set the shadow bad flag.
REQ-025 SHALL implement a stall counter that clears on every state advance or commit and increments otherwise in S3..S0. It holds at 0 in HUNT when Stalled=1, and saturates at STALL_CYCLES.
REQ-026 SHALL, when the stall counter reaches STALL_CYCLES, set Stalled, clear FrameValid, and go to HUNT. Value/DPMask hold their last contents.
REQ-027 SHALL give simultaneous-event priority as follows: multi-hot > timeout > commit/advance > capture.
REQ-028 SHALL size the stall counter as clog2(STALL_CYCLES+1) bits.

Reset
REQ-029 SHALL, while nReset=0 at a rising edge, set state=HUNT and clear the shadow, bad flag and stall counter. Outputs are Value=0, DPMask=0, FrameStrobe=0, FrameValid=0, SeqErr=0, BcdErr=0, Stalled=0.
REQ-030 SHALL make reset asserted mid-frame discard the partial shadow. No FrameStrobe occurs during or after reset until a full S3..S0 scan plus 1000 is observed.
REQ-031 SHALL resume capture starting at the first 1000 select sampled after nReset returns high.

Verification
REQ-032 Bench SHALL cover: a scan of 1000/D=1, 0100/D=2, 0010/D=3 DP=1, 0001/D=4, then 1000. Value=0x1234, DPMask=0010, a single-cycle FrameStrobe one cycle later, and FrameValid=1.
REQ-033 Bench SHALL cover: the same scan with 0000 blanking gaps of 3 cycles between digits. The result is identical to REQ-032, with no SeqErr.
REQ-034 Bench SHALL cover: a scan of 1000, 0100, then 0001 (skipping 0010). Result: SeqErr pulse, HUNT, Value unchanged, and no FrameStrobe on the next 1000.
REQ-035 Bench SHALL cover: slot 1 with D=0xB. Result: BcdErr pulse and no commit at the following 1000. The next clean scan commits normally.
REQ-036 Bench SHALL cover: STALL_CYCLES=8 with Digit held at 0100 after a valid frame. Stalled=1 and FrameValid=0 after 8 cycles; Value keeps its old frame; a subsequent clean frame clears Stalled.
REQ-037 Bench SHALL cover: nReset pulsed low while in S1. All outputs read 0. Restarting a scan at 0100 yields no strobe until a 1000-started full scan completes.

Source files
------------

// File: rtl/display_capture.sv
// display_capture: reassembles a multiplexed 4-digit BCD display scan into committed frames
module display_capture #(
  parameter int STALL_CYCLES = 4096
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [3:0]  D,
  input  logic [3:0]  Digit,
  input  logic        DP,
  output logic [15:0] Value,
  output logic [3:0]  DPMask,
  output logic        FrameStrobe,
  output logic        FrameValid,
  output logic        SeqErr,
  output logic        BcdErr,
  output logic        Stalled
);
  localparam int CW = $clog2(STALL_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STALL_CYCLES - 1);
  typedef enum logic [2:0] {HUNT, S3, S2, S1, S0} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] shadow;
  logic [3:0]  shadow_dp;
  logic        bad;
  logic        multi, clr, cap, commit, seq, timeout;
  logic [3:0]  cur_sel;
  logic [1:0]  sel_idx;
  assign multi   = |(Digit & (Digit - 4'd1));
  assign sel_idx = Digit[3] ? 2'd3 : Digit[2] ? 2'd2 : Digit[1] ? 2'd1 : 2'd0;
  assign cur_sel = state == S3 ? 4'b1000 : state == S2 ? 4'b0100 :
                   state == S1 ? 4'b0010 : state == S0 ? 4'b0001 : 4'b0000;
  // next state: multi-hot beats timeout beats commit/advance beats capture; a select that
  // enters a slot also captures that slot's data in the same cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clr     = 1'b0;
    cap     = 1'b0;
    commit  = 1'b0;
    seq     = 1'b0;
    timeout = 1'b0;
    if (multi) begin
      seq     = 1'b1;
      state_n = HUNT;
      cnt_n   = '0;
    end else if (state == HUNT) begin
      cnt_n = '0;
      if (Digit == 4'b1000) begin
        state_n = S3;
        clr     = 1'b1;
        cap     = 1'b1;
      end
    end else if (cnt == LAST) begin
      timeout = 1'b1;
      state_n = HUNT;
      cnt_n   = '0;
    end else if (Digit == 4'b0000) begin
      cnt_n = cnt + 1'b1;
    end else if (Digit == cur_sel) begin
      cap   = 1'b1;
      cnt_n = cnt + 1'b1;
    end else if (Digit == {1'b0, cur_sel[3:1]}) begin
      state_n = state == S3 ? S2 : state == S2 ? S1 : S0;
      cap     = 1'b1;
      cnt_n   = '0;
    end else if (Digit == 4'b1000) begin
      commit  = state == S0 && !bad;
      seq     = state != S0;
      state_n = S3;
      clr     = 1'b1;
      cap     = 1'b1;
      cnt_n   = '0;
    end else begin
      seq     = 1'b1;
      state_n = HUNT;
      cnt_n   = '0;
    end
  end
  // state, shadow capture, frame commit and status pulses
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state       <= HUNT;
      cnt         <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      bad         <= 1'b0;
      Value       <= '0;
      DPMask      <= '0;
      FrameStrobe <= 1'b0;
      FrameValid  <= 1'b0;
      SeqErr      <= 1'b0;
      BcdErr      <= 1'b0;
      Stalled     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      FrameStrobe <= commit;
      SeqErr      <= seq;
      BcdErr      <= cap && D > 4'd9;
      if (commit) begin
        Value      <= shadow;
        DPMask     <= shadow_dp;
        FrameValid <= 1'b1;
        Stalled    <= 1'b0;
      end
      if (timeout) begin
        FrameValid <= 1'b0;
        Stalled    <= 1'b1;
      end
      if (clr) begin
        shadow    <= '0;
        shadow_dp <= '0;
        bad       <= 1'b0;
      end
      if (cap) begin
        shadow[{sel_idx, 2'b00} +: 4] <= D;
        shadow_dp[sel_idx]            <= DP;
        if (D > 4'd9) bad <= 1'b1;
      end
    end
  end
endmodule
